// File: rtl/char_pkg.sv
// Shared types and helpers for the jump-game character controller.
// State encoding, facing constants and a symmetric saturating adder.
package char_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WALK   = 2'd1,
        ST_CHARGE = 2'd2,
        ST_AIR    = 2'd3
    } state_t;

    localparam logic signed [1:0] FACE_RIGHT = 2'sb01;
    localparam logic signed [1:0] FACE_LEFT  = 2'sb11;

    function automatic int sat_add(input int a, input int b, input int lim);
        int s;
        s = a + b;
        if (s > lim) return lim;
        if (s < -lim) return -lim;
        return s;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button synchroniser chain with rising-edge detect; level lags the pin by STAGES clocks.
// rise is a single-cycle pulse aligned with the first synced-high cycle.
module btn_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= (chain << 1) | STAGES'(btn);
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;

endmodule

// File: rtl/char_motion_ctrl.sv
// Player-character physics: walk, charged jump, gravity, wall bounce, ceiling and floor.
// State advances only on tick; outputs settle the cycle after; bounce/land are 1-cycle pulses.
module char_motion_ctrl
    import char_pkg::*;
#(
    parameter int POS_W             = 11,
    parameter int VEL_W             = 8,
    parameter int MAP_X_MIN         = 10,
    parameter int MAP_X_MAX         = 310,
    parameter int MAP_Y_MIN         = 10,
    parameter int MAP_Y_MAX         = 230,
    parameter int CHAR_W            = 32,
    parameter int CHAR_H            = 32,
    parameter int INIT_X            = 144,
    parameter int INIT_Y            = 10,
    parameter int WALK_STEP         = 1,
    parameter int GRAVITY           = 1,
    parameter int MAX_VEL           = 30,
    parameter int JUMP_VX           = 3,
    parameter int JUMP_VY           = 6,
    parameter int CHARGE_LEVELS     = 4,
    parameter int CHARGE_STEP_TICKS = 8,
    parameter int SYNC_STAGES       = 2
) (
    input  logic                               sys_clk,
    input  logic                               sys_rst,
    input  logic                               tick,
    input  logic                               left_btn,
    input  logic                               right_btn,
    input  logic                               jump_btn,
    output logic signed [POS_W-1:0]            pos_x,
    output logic signed [POS_W-1:0]            pos_y,
    output logic signed [VEL_W-1:0]            vel_x,
    output logic signed [VEL_W-1:0]            vel_y,
    output logic signed [1:0]                  face,
    output logic [$clog2(CHARGE_LEVELS+1)-1:0] charge_level,
    output logic [1:0]                         state,
    output logic                               on_ground,
    output logic                               bounce,
    output logic                               land
);

    localparam int LVL_W   = $clog2(CHARGE_LEVELS + 1);
    localparam int CNT_MAX = CHARGE_LEVELS * CHARGE_STEP_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int X_LO    = MAP_X_MIN;
    localparam int X_HI    = MAP_X_MAX - CHAR_W;
    localparam int Y_LO    = MAP_Y_MIN;
    localparam int Y_HI    = MAP_Y_MAX - CHAR_H;
    localparam int VEL_LIM = (CHAR_W < CHAR_H) ? CHAR_W : CHAR_H;

    // A velocity larger than the sprite could tunnel through a wall in one tick.
    if (MAX_VEL > VEL_LIM) begin : g_bad_max_vel
        $error("MAX_VEL must not exceed min(CHAR_W, CHAR_H)");
    end
    if (INIT_Y != MAP_Y_MIN) begin : g_bad_init_y
        $error("INIT_Y must equal MAP_Y_MIN");
    end

    logic left_lvl, right_lvl, jump_lvl;
    logic left_rise, right_rise, jump_rise;
    logic unused_rise;

    btn_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_left (
        .clk(sys_clk), .rst(sys_rst), .btn(left_btn), .level(left_lvl), .rise(left_rise)
    );
    btn_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_right (
        .clk(sys_clk), .rst(sys_rst), .btn(right_btn), .level(right_lvl), .rise(right_rise)
    );
    btn_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_jump (
        .clk(sys_clk), .rst(sys_rst), .btn(jump_btn), .level(jump_lvl), .rise(jump_rise)
    );

    assign unused_rise = left_rise | right_rise;

    state_t                  cur_st, nxt_st;
    logic signed [POS_W-1:0] nxt_pos_x, nxt_pos_y;
    logic signed [VEL_W-1:0] nxt_vel_x, nxt_vel_y, vy_grav;
    logic signed [1:0]       nxt_face;
    logic [CNT_W-1:0]        cnt, nxt_cnt;
    logic                    jump_req, jump_go, one_dir;
    logic                    nxt_bounce, nxt_land;
    logic signed [POS_W:0]   step, wx, nx, ny;
    int                      lvl, jvx, jvy;

    always_comb begin
        lvl = 1 + int'(cnt) / CHARGE_STEP_TICKS;
        if (lvl > CHARGE_LEVELS) lvl = CHARGE_LEVELS;
    end

    assign charge_level = (cur_st == ST_CHARGE) ? LVL_W'(lvl) : '0;
    assign state        = cur_st;
    assign on_ground    = (cur_st != ST_AIR);
    assign jump_go      = jump_req | jump_rise;
    assign one_dir      = left_lvl ^ right_lvl;

    always_comb begin
        nxt_st     = cur_st;
        nxt_pos_x  = pos_x;
        nxt_pos_y  = pos_y;
        nxt_vel_x  = vel_x;
        nxt_vel_y  = vel_y;
        nxt_face   = face;
        nxt_cnt    = cnt;
        nxt_bounce = 1'b0;
        nxt_land   = 1'b0;

        step    = left_lvl ? -(POS_W+1)'(WALK_STEP) : (POS_W+1)'(WALK_STEP);
        wx      = (POS_W+1)'(pos_x) + step;
        nx      = (POS_W+1)'(pos_x) + (POS_W+1)'(vel_x);
        ny      = (POS_W+1)'(pos_y) + (POS_W+1)'(vel_y);
        vy_grav = VEL_W'(sat_add(int'(vel_y), -GRAVITY, MAX_VEL));
        jvx     = sat_add(JUMP_VX * lvl, 0, MAX_VEL);
        if (face == FACE_LEFT) jvx = -jvx;
        jvy     = sat_add(JUMP_VY * lvl, 0, MAX_VEL);

        case (cur_st)
            ST_IDLE, ST_WALK: begin
                if (jump_go || jump_lvl) begin
                    nxt_st  = ST_CHARGE;
                    nxt_cnt = '0;
                end else if (one_dir) begin
                    nxt_st   = ST_WALK;
                    nxt_face = left_lvl ? FACE_LEFT : FACE_RIGHT;
                    if (wx < X_LO)      nxt_pos_x = POS_W'(X_LO);
                    else if (wx > X_HI) nxt_pos_x = POS_W'(X_HI);
                    else                nxt_pos_x = wx[POS_W-1:0];
                end else begin
                    nxt_st = ST_IDLE;
                end
            end
            ST_CHARGE: begin
                nxt_vel_x = '0;
                nxt_vel_y = '0;
                if (!jump_lvl || cnt == CNT_W'(CNT_MAX)) begin
                    nxt_st    = ST_AIR;
                    nxt_vel_x = VEL_W'(jvx);
                    nxt_vel_y = VEL_W'(jvy);
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                    if (one_dir) nxt_face = left_lvl ? FACE_LEFT : FACE_RIGHT;
                end
            end
            ST_AIR: begin
                nxt_pos_x = nx[POS_W-1:0];
                nxt_pos_y = ny[POS_W-1:0];
                nxt_vel_y = vy_grav;
                if (nx < X_LO) begin
                    nxt_pos_x  = POS_W'(X_LO);
                    nxt_vel_x  = -vel_x;
                    nxt_face   = -face;
                    nxt_bounce = 1'b1;
                end else if (nx > X_HI) begin
                    nxt_pos_x  = POS_W'(X_HI);
                    nxt_vel_x  = -vel_x;
                    nxt_face   = -face;
                    nxt_bounce = 1'b1;
                end
                if (ny > Y_HI) begin
                    nxt_pos_y = POS_W'(Y_HI);
                    nxt_vel_y = '0;
                end
                // Landing wins over any wall reflection of vel_x.
                if (ny <= Y_LO && vel_y <= 0) begin
                    nxt_pos_y = POS_W'(Y_LO);
                    nxt_vel_x = '0;
                    nxt_vel_y = '0;
                    nxt_st    = ST_IDLE;
                    nxt_land  = 1'b1;
                end
            end
            default: nxt_st = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cur_st   <= ST_IDLE;
            pos_x    <= POS_W'(INIT_X);
            pos_y    <= POS_W'(INIT_Y);
            vel_x    <= '0;
            vel_y    <= '0;
            face     <= FACE_RIGHT;
            cnt      <= '0;
            jump_req <= 1'b0;
            bounce   <= 1'b0;
            land     <= 1'b0;
        end else begin
            jump_req <= tick ? 1'b0 : jump_go;
            bounce   <= tick & nxt_bounce;
            land     <= tick & nxt_land;
            if (tick) begin
                cur_st <= nxt_st;
                pos_x  <= nxt_pos_x;
                pos_y  <= nxt_pos_y;
                vel_x  <= nxt_vel_x;
                vel_y  <= nxt_vel_y;
                face   <= nxt_face;
                cnt    <= nxt_cnt;
            end
        end
    end

endmodule

// File: doc/char_motion_ctrl.md
Name: char_motion_ctrl

Overview:
Parametrised player-character physics controller for the VGA jump game. It runs on one system clock and advances once per `tick` strobe (frame rate), replacing the separate character clock. Movement covers walk, charged jump with N levels, gravity, wall bounce, ceiling clamp and floor landing. Outputs feed the sprite renderer and debug display.

Parameters:
POS_W, 11, signed position width
VEL_W, 8, signed velocity width
MAP_X_MIN, 10, left wall inner edge (x grows rightward)
MAP_X_MAX, 310, right wall inner edge
MAP_Y_MIN, 10, floor (y grows upward; pos_y is the character's bottom edge)
MAP_Y_MAX, 230, ceiling
CHAR_W, 32, sprite width
CHAR_H, 32, sprite height
INIT_X, 144, reset x
INIT_Y, 10, reset y; must equal MAP_Y_MIN
WALK_STEP, 1, px per tick while walking
GRAVITY, 1, vel_y decrement per AIR tick
MAX_VEL, 30, velocity saturation; elaboration error if MAX_VEL > min(CHAR_W,CHAR_H)
JUMP_VX, 3, horizontal launch velocity per level
JUMP_VY, 6, vertical launch velocity per level
CHARGE_LEVELS, 4, number of charge levels
CHARGE_STEP_TICKS, 8, ticks per charge level
SYNC_STAGES, 2, button synchroniser depth

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  reset, asynchronous, active-high
tick  in  1  one-cycle update strobe
left_btn  in  1  raw asynchronous button level
right_btn  in  1  raw asynchronous button level
jump_btn  in  1  raw asynchronous button level
pos_x  out  POS_W  character left edge, signed
pos_y  out  POS_W  character bottom edge, signed
vel_x  out  VEL_W  signed velocity
vel_y  out  VEL_W  signed velocity
face  out  2  signed; +1 = right, -1 = left
charge_level  out  clog2(CHARGE_LEVELS+1)  0 when not charging
state  out  2  IDLE=0, WALK=1, CHARGE=2, AIR=3
on_ground  out  1  high in IDLE, WALK and CHARGE
bounce  out  1  one-cycle pulse on a wall hit
land  out  1  one-cycle pulse on landing

Behaviour:
- Reset values: pos=(INIT_X,INIT_Y), vel=0, face=+1, charge_level=0, state=IDLE, on_ground=1, bounce=land=0. Reset mid-jump is immediate and restores the same values.
- Buttons pass through a SYNC_STAGES flop chain. Jump rising edge sets a sticky `jump_req`, which is cleared on tick. Left and right act as synced levels.
- All architectural regs update only on a sys_clk edge where tick=1; outputs are valid the following cycle. No tick means no change.
- IDLE: jump_req or synced jump high -> CHARGE (highest priority); exactly one of left/right -> WALK; both or none -> stay.
- WALK: pos_x ±= WALK_STEP and face follows the direction. pos_x is clamped to [MAP_X_MIN, MAP_X_MAX-CHAR_W] with no bounce. Jump -> CHARGE; no direction -> IDLE.
- CHARGE: vel=0. charge_cnt increments per tick, saturating at CHARGE_LEVELS*CHARGE_STEP_TICKS. charge_level = min(1 + charge_cnt/CHARGE_STEP_TICKS, CHARGE_LEVELS). Left/right only change face.
- Launch from CHARGE happens when synced jump is low or charge_cnt is saturated. On launch: vel_x=JUMP_VX*level*face, vel_y=JUMP_VY*level, both saturated to ±MAX_VEL; pos unchanged; charge_cnt=0; state -> AIR.
- AIR: compute nx=pos_x+vel_x, ny=pos_y+vel_y, with sums in POS_W+1 bits. Then vel_y -= GRAVITY, saturating at -MAX_VEL. Buttons are ignored; jump_req is discarded.
  - nx < MAP_X_MIN: pos_x=MAP_X_MIN, vel_x=-vel_x, face=-face, bounce.
  - nx > MAP_X_MAX-CHAR_W: mirror case at the right wall.
  - ny > MAP_Y_MAX-CHAR_H: pos_y=MAP_Y_MAX-CHAR_H, vel_y=0.
  - ny <= MAP_Y_MIN with vel_y <= 0: pos_y=MAP_Y_MIN, vel=0, state=IDLE, land.
- Wall and floor hit in the same tick: both corrections apply, both pulses fire, and the final state is IDLE.
- bounce and land assert for exactly one sys_clk cycle.

Decomposition:
- Package char_pkg holds the state encoding, FACE_LEFT/FACE_RIGHT constants and the sat_add function.
- Sub-module btn_sync_edge (synchroniser plus rising-edge detect), instantiated three times.

Test Plan:
1. Reset, hold right for 5 ticks -> pos_x=149, face=+1, state=WALK; release -> IDLE, pos unchanged.
2. Hold left for 140 ticks -> pos_x stops at 10, bounce never pulses; pressing left and right together -> no motion, state=IDLE.
3. Jump pressed then released within 1 tick -> charge_level=1, launch vel=(3,6). Land on AIR tick 13 with pos=(183,10), vel=0, one land pulse.
4. Hold jump for 40 ticks -> auto-launch at charge_cnt=32, level 4, vel=(12,24). AIR tick 10: pos_y=198, vel_y=0. AIR tick 12: pos_x=278, vel_x=-12, face=-1, one bounce pulse.
5. Assert sys_rst during AIR, asynchronously between clock edges -> outputs equal reset values at once; state=IDLE, charge_level=0.
6. Hold tick low for 100 cycles while toggling buttons -> all outputs unchanged; a jump edge during that window is still honoured on the next tick (state -> CHARGE).
